led_scanner: RTL and testbench
==============================

Name: led_scanner

Overview:
- Parametrised successor to the fixed 6-LED chaser on the board top level.
- Drives NUM_LEDS outputs with a selectable scan pattern: bounce, wrap-up, wrap-down or blink-all.
- Step rate is derived from the clock frequency, a millisecond base period and a runtime speed input.
- Sits between the top-level Clock and the LED pins; exports a step strobe and the current position for other logic, such as the UART reporter.

Parameters:
- CLOCK_FREQUENCY, 27000000, input clock in Hz.
- STEP_MS, 100, base step period in ms; TICK_CYCLES = (CLOCK_FREQUENCY/1000)*STEP_MS; must be >= 1.
- NUM_LEDS, 6, number of LEDs; legal range 2..32.
- ACTIVE_LOW, 1, 1 = Leds output inverted (pin low = LED on).

Ports:
- Clock  input  1  system clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Enable  input  1  1 = run; 0 = freeze all counters and state.
- Mode  input  2  00 bounce, 01 wrap-up, 10 wrap-down, 11 blink-all.
- Speed  input  4  step occurs every (Speed+1) base periods.
- Leds  output  NUM_LEDS  LED drive, polarity per ACTIVE_LOW.
- Step  output  1  one-cycle pulse on the cycle the pattern updates.
- Position  output  PW = max(1, $clog2(NUM_LEDS))  index of lit LED; 0 in blink-all.

Behaviour:
- Reset (async assert, sync release): tick_cnt=0, div_cnt=0, pos=0, dir=up, blink_phase=0, cur_mode=00, Step=0, Position=0, Leds = one-hot bit 0 (inverted if ACTIVE_LOW).
- Prescaler: tick_cnt counts 0..TICK_CYCLES-1. On wrap, a base tick fires and div_cnt counts 0..Speed. On div_cnt==Speed together with a base tick, a step fires and div_cnt clears.
- Speed is sampled live. If Speed is lowered below the current div_cnt, the step fires at the next base tick and div_cnt clears; no 16-period stall.
- Step is registered: high exactly one cycle, the same cycle the new Leds/Position become visible.
- Enable=0: tick_cnt, div_cnt, pos, dir and blink_phase hold; Step=0; Leds hold. Re-enabling resumes mid-period with no restart.
- Mode is sampled only at a step.
  - If Mode != cur_mode, cur_mode is updated and the pattern restarts in that step.
  - Restart values: wrap-down pos=NUM_LEDS-1; bounce and wrap-up pos=0, dir=up; blink-all blink_phase=1 (all on).
  - A restart step emits Step=1 but performs no movement.
- Bounce: no dwell at the ends.
  - dir=up with pos=NUM_LEDS-1: dir becomes down and pos=NUM_LEDS-2 in the same step.
  - dir=down with pos=0: dir becomes up and pos=1.
  - Otherwise pos moves by ±1.
- Wrap-up: pos+1, NUM_LEDS-1 wraps to 0.
- Wrap-down: pos-1, 0 wraps to NUM_LEDS-1.
- Blink-all: blink_phase toggles each step. Pattern is all ones when phase=1, all zeros when phase=0. Position=0.
- Pattern (pre-polarity) is one-hot(pos) for the scan modes. Leds = ACTIVE_LOW ? ~pattern : pattern, registered.
- Reset mid-step or mid-period: immediate return to reset values; no partial Step pulse.
- Arithmetic: pos is PW bits and never exceeds NUM_LEDS-1, including for non-power-of-2 NUM_LEDS; wrap is by compare, not overflow. tick_cnt is 32 bits; div_cnt is 4 bits.

Optional Feature:
- Macro LED_SCANNER_TRAIL_EN.
- When defined, scan modes light a two-LED comet: pattern = one-hot(pos) | one-hot(prev_pos).
  - prev_pos is the position before the last step.
  - At reset or on a mode restart, prev_pos = pos, so a single LED is lit.
  - Blink-all is unaffected.
- When undefined, prev_pos logic is not present and the pattern is strictly one-hot.

Test Plan:
Sim parameters: CLOCK_FREQUENCY=4000, STEP_MS=1 (TICK_CYCLES=4), NUM_LEDS=6, ACTIVE_LOW=1.
- Reset, Mode=00, Speed=0, Enable=1 -> Step every 4 cycles. Position sequence 0,1,2,3,4,5,4,3,2,1,0,1. Leds at pos 5 = 6'b011111.
- Mode=01, Speed=2 -> steps 12 cycles apart; Position 0..5,0. Switch to Mode=10 -> next step is a restart to Position 5, then 4.
- Mode=11 -> Leds alternate 6'b000000 / 6'b111111 each step; Position stays 0.
- Enable=0 for 50 cycles mid-period -> no Step, Leds constant. Enable=1 -> next Step after the remaining period only.
- Reset_n pulsed low asynchronously between edges mid-scan at Position 3 -> outputs return to Position 0, Leds 6'b111110, Step 0, before the next edge.
- NUM_LEDS=5, wrap-up, with and without LED_SCANNER_TRAIL_EN -> Position wraps 4->0. Trail build shows Leds 5'b11100 at pos 1 (bits 0,1 lit), then 5'b11001 after the step to pos 2.

Source files
------------

// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - parametrised LED scanner (bounce/wrap-up/wrap-down/blink) with step strobe and position
// Optional macro LED_SCANNER_TRAIL_EN: scan modes light a two-LED comet (current and previous position).
module led_scanner #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int STEP_MS         = 100,
    parameter int NUM_LEDS        = 6,
    parameter bit ACTIVE_LOW      = 1'b1,
    localparam int PW             = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Enable,
    input  logic [1:0]          Mode,
    input  logic [3:0]          Speed,
    output logic [NUM_LEDS-1:0] Leds,
    output logic                Step,
    output logic [PW-1:0]       Position
);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    localparam int unsigned         TICK_CYCLES   = (CLOCK_FREQUENCY / 1000) * STEP_MS;
    localparam logic [31:0]         TICK_LAST     = 32'(TICK_CYCLES - 1);
    localparam logic [PW-1:0]       POS_LAST      = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0]       POS_TURN      = PW'(NUM_LEDS - 2);
    localparam logic [PW-1:0]       POS_ONE       = PW'(1);
    localparam logic [NUM_LEDS-1:0] ONE_HOT0      = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] RESET_LEDS    = ACTIVE_LOW ? ~ONE_HOT0 : ONE_HOT0;

    logic [31:0]         tick_cnt;
    logic [3:0]          div_cnt;
    logic [PW-1:0]       pos;
    logic                dir_up;
    logic                blink_phase;
    mode_t               cur_mode;

    mode_t               nxt_mode;
    logic [PW-1:0]       nxt_pos;
    logic                nxt_dir;
    logic                nxt_phase;
    logic [NUM_LEDS-1:0] pattern;

`ifdef LED_SCANNER_TRAIL_EN
    logic [PW-1:0]       prev_pos;
    logic [PW-1:0]       nxt_prev;
`endif

    function automatic logic [NUM_LEDS-1:0] one_hot(input logic [PW-1:0] p);
        return ONE_HOT0 << p;
    endfunction

    // State the pattern moves to if a step fires this cycle.
    always_comb begin
        nxt_mode  = cur_mode;
        nxt_pos   = pos;
        nxt_dir   = dir_up;
        nxt_phase = blink_phase;
`ifdef LED_SCANNER_TRAIL_EN
        nxt_prev  = prev_pos;
`endif
        if (mode_t'(Mode) != cur_mode) begin
            nxt_mode = mode_t'(Mode);
            case (mode_t'(Mode))
                MODE_DOWN:  nxt_pos = POS_LAST;
                MODE_BLINK: nxt_phase = 1'b1;
                default: begin
                    nxt_pos = '0;
                    nxt_dir = 1'b1;
                end
            endcase
`ifdef LED_SCANNER_TRAIL_EN
            nxt_prev = nxt_pos;
`endif
        end else begin
`ifdef LED_SCANNER_TRAIL_EN
            if (cur_mode != MODE_BLINK)
                nxt_prev = pos;
`endif
            case (cur_mode)
                MODE_BOUNCE: begin
                    if (dir_up) begin
                        if (pos == POS_LAST) begin
                            nxt_dir = 1'b0;
                            nxt_pos = POS_TURN;
                        end else begin
                            nxt_pos = pos + POS_ONE;
                        end
                    end else begin
                        if (pos == '0) begin
                            nxt_dir = 1'b1;
                            nxt_pos = POS_ONE;
                        end else begin
                            nxt_pos = pos - POS_ONE;
                        end
                    end
                end
                MODE_UP:    nxt_pos = (pos == POS_LAST) ? '0 : pos + POS_ONE;
                MODE_DOWN:  nxt_pos = (pos == '0) ? POS_LAST : pos - POS_ONE;
                MODE_BLINK: nxt_phase = ~blink_phase;
            endcase
        end
    end

    always_comb begin
        if (nxt_mode == MODE_BLINK) begin
            pattern = {NUM_LEDS{nxt_phase}};
        end else begin
`ifdef LED_SCANNER_TRAIL_EN
            pattern = one_hot(nxt_pos) | one_hot(nxt_prev);
`else
            pattern = one_hot(nxt_pos);
`endif
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt    <= '0;
            div_cnt     <= '0;
            pos         <= '0;
            dir_up      <= 1'b1;
            blink_phase <= 1'b0;
            cur_mode    <= MODE_BOUNCE;
            Step        <= 1'b0;
            Position    <= '0;
            Leds        <= RESET_LEDS;
`ifdef LED_SCANNER_TRAIL_EN
            prev_pos    <= '0;
`endif
        end else begin
            Step <= 1'b0;
            if (Enable) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    // >= so that lowering Speed below div_cnt steps at the next tick instead of stalling.
                    if (div_cnt >= Speed) begin
                        div_cnt     <= '0;
                        Step        <= 1'b1;
                        cur_mode    <= nxt_mode;
                        pos         <= nxt_pos;
                        dir_up      <= nxt_dir;
                        blink_phase <= nxt_phase;
                        Position    <= (nxt_mode == MODE_BLINK) ? '0 : nxt_pos;
                        Leds        <= ACTIVE_LOW ? ~pattern : pattern;
`ifdef LED_SCANNER_TRAIL_EN
                        prev_pos    <= nxt_prev;
`endif
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end else begin
                    tick_cnt <= tick_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - self-checking bench for led_scanner (6-LED and 5-LED instances, 4-cycle base tick)
module tb_led_scanner;

    localparam int TB_TICK = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] speed = 4'd0;

    logic [5:0] leds0;
    logic       step0;
    logic [2:0] pos0;
    logic [4:0] leds5;
    logic       step5;
    logic [2:0] pos5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_scanner #(.CLOCK_FREQUENCY(4000), .STEP_MS(1), .NUM_LEDS(6), .ACTIVE_LOW(1'b1)) dut6 (
        .Clock(clk), .Reset_n(rst_n), .Enable(en), .Mode(mode), .Speed(speed),
        .Leds(leds0), .Step(step0), .Position(pos0)
    );

    led_scanner #(.CLOCK_FREQUENCY(4000), .STEP_MS(1), .NUM_LEDS(5), .ACTIVE_LOW(1'b1)) dut5 (
        .Clock(clk), .Reset_n(rst_n), .Enable(1'b1), .Mode(2'b01), .Speed(4'd0),
        .Leds(leds5), .Step(step5), .Position(pos5)
    );

    // Reference model: k counts steps since the last (re)start; positions come from closed-form sequences.
    int          m_n [2] = '{6, 5};
    int          m_cyc [2];
    int          m_bt [2];
    int          m_k [2];
    logic [1:0]  m_mode [2];
    logic        m_step [2];
    int          m_pos [2];
    logic [31:0] m_leds [2];

    function automatic int scan_pos(input logic [1:0] md, input int k, input int n);
        int per;
        per = 2 * n - 2;
        case (md)
            2'b00:   return ((k % per) < n) ? (k % per) : (per - (k % per));
            2'b01:   return k % n;
            2'b10:   return n - 1 - (k % n);
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] leds_of(input logic [1:0] md, input int k, input int n);
        logic [31:0] pat;
        logic [31:0] mask;
        mask = (32'd1 << n) - 32'd1;
        if (md == 2'b11) begin
            pat = ((k % 2) == 0) ? mask : 32'd0;
        end else begin
            pat = 32'd1 << scan_pos(md, k, n);
`ifdef LED_SCANNER_TRAIL_EN
            if (k > 0) pat = pat | (32'd1 << scan_pos(md, k - 1, n));
`endif
        end
        return ~pat & mask;
    endfunction

    task automatic m_reset(input int i);
        m_cyc[i]  = 0;
        m_bt[i]   = 0;
        m_k[i]    = 0;
        m_mode[i] = 2'b00;
        m_step[i] = 1'b0;
        m_pos[i]  = 0;
        m_leds[i] = leds_of(2'b00, 0, m_n[i]);
    endtask

    task automatic m_clock(input int i, input logic e, input logic [1:0] md, input logic [3:0] sp);
        m_step[i] = 1'b0;
        if (e) begin
            m_cyc[i] = (m_cyc[i] + 1) % TB_TICK;
            if (m_cyc[i] == 0) begin
                m_bt[i]++;
                if (m_bt[i] > int'(sp)) begin
                    m_bt[i] = 0;
                    if (md != m_mode[i]) begin
                        m_mode[i] = md;
                        m_k[i] = 0;
                    end else begin
                        m_k[i]++;
                    end
                    m_step[i] = 1'b1;
                    m_pos[i]  = scan_pos(m_mode[i], m_k[i], m_n[i]);
                    m_leds[i] = leds_of(m_mode[i], m_k[i], m_n[i]);
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_clock(0, en, mode, speed);
            m_clock(1, 1'b1, 2'b01, 4'd0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_step(input int which, output int gap);
        logic s;
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
            s = (which == 0) ? step0 : step5;
        end while (!s && gap < 300);
        if (!s) begin
            checks++;
            errors++;
            $display("FAIL step_timeout actual=no_step required=step within 300 cycles (inst %0d)", which);
        end
    endtask

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] speed;
        int         gap;
        int         pos;
        logic [5:0] leds;
    } vec_t;

    vec_t vecs [23];
    int   exp5_pos [6] = '{0, 1, 2, 3, 4, 0};
`ifdef LED_SCANNER_TRAIL_EN
    logic [4:0] exp5_leds [6] = '{5'b11110, 5'b11100, 5'b11001, 5'b10011, 5'b00111, 5'b01110};
`else
    logic [4:0] exp5_leds [6] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110};
`endif

    initial begin
        int   g;
        logic stepped;
        logic changed;
        logic [5:0] held;

`ifdef LED_SCANNER_TRAIL_EN
        vecs[0]  = '{1'b1, 2'd0, 4'd0, 4, 1, 6'b111100};
        vecs[1]  = '{1'b1, 2'd0, 4'd0, 4, 2, 6'b111001};
        vecs[2]  = '{1'b1, 2'd0, 4'd0, 4, 3, 6'b110011};
        vecs[3]  = '{1'b1, 2'd0, 4'd0, 4, 4, 6'b100111};
        vecs[4]  = '{1'b1, 2'd0, 4'd0, 4, 5, 6'b001111};
        vecs[5]  = '{1'b1, 2'd0, 4'd0, 4, 4, 6'b001111};
        vecs[6]  = '{1'b1, 2'd0, 4'd0, 4, 3, 6'b100111};
        vecs[7]  = '{1'b1, 2'd0, 4'd0, 4, 2, 6'b110011};
        vecs[8]  = '{1'b1, 2'd0, 4'd0, 4, 1, 6'b111001};
        vecs[9]  = '{1'b1, 2'd0, 4'd0, 4, 0, 6'b111100};
        vecs[10] = '{1'b1, 2'd0, 4'd0, 4, 1, 6'b111100};
        vecs[11] = '{1'b1, 2'd1, 4'd2, 12, 0, 6'b111110};
        vecs[12] = '{1'b1, 2'd1, 4'd2, 12, 1, 6'b111100};
        vecs[13] = '{1'b1, 2'd1, 4'd2, 12, 2, 6'b111001};
        vecs[14] = '{1'b1, 2'd1, 4'd2, 12, 3, 6'b110011};
        vecs[15] = '{1'b1, 2'd1, 4'd2, 12, 4, 6'b100111};
        vecs[16] = '{1'b1, 2'd1, 4'd2, 12, 5, 6'b001111};
        vecs[17] = '{1'b1, 2'd1, 4'd2, 12, 0, 6'b011110};
        vecs[18] = '{1'b1, 2'd2, 4'd2, 12, 5, 6'b011111};
        vecs[19] = '{1'b1, 2'd2, 4'd2, 12, 4, 6'b001111};
`else
        vecs[0]  = '{1'b1, 2'd0, 4'd0, 4, 1, 6'b111101};
        vecs[1]  = '{1'b1, 2'd0, 4'd0, 4, 2, 6'b111011};
        vecs[2]  = '{1'b1, 2'd0, 4'd0, 4, 3, 6'b110111};
        vecs[3]  = '{1'b1, 2'd0, 4'd0, 4, 4, 6'b101111};
        vecs[4]  = '{1'b1, 2'd0, 4'd0, 4, 5, 6'b011111};
        vecs[5]  = '{1'b1, 2'd0, 4'd0, 4, 4, 6'b101111};
        vecs[6]  = '{1'b1, 2'd0, 4'd0, 4, 3, 6'b110111};
        vecs[7]  = '{1'b1, 2'd0, 4'd0, 4, 2, 6'b111011};
        vecs[8]  = '{1'b1, 2'd0, 4'd0, 4, 1, 6'b111101};
        vecs[9]  = '{1'b1, 2'd0, 4'd0, 4, 0, 6'b111110};
        vecs[10] = '{1'b1, 2'd0, 4'd0, 4, 1, 6'b111101};
        vecs[11] = '{1'b1, 2'd1, 4'd2, 12, 0, 6'b111110};
        vecs[12] = '{1'b1, 2'd1, 4'd2, 12, 1, 6'b111101};
        vecs[13] = '{1'b1, 2'd1, 4'd2, 12, 2, 6'b111011};
        vecs[14] = '{1'b1, 2'd1, 4'd2, 12, 3, 6'b110111};
        vecs[15] = '{1'b1, 2'd1, 4'd2, 12, 4, 6'b101111};
        vecs[16] = '{1'b1, 2'd1, 4'd2, 12, 5, 6'b011111};
        vecs[17] = '{1'b1, 2'd1, 4'd2, 12, 0, 6'b111110};
        vecs[18] = '{1'b1, 2'd2, 4'd2, 12, 5, 6'b011111};
        vecs[19] = '{1'b1, 2'd2, 4'd2, 12, 4, 6'b101111};
`endif
        vecs[20] = '{1'b1, 2'd3, 4'd0, 4, 0, 6'b000000};
        vecs[21] = '{1'b1, 2'd3, 4'd0, 4, 0, 6'b111111};
        vecs[22] = '{1'b1, 2'd3, 4'd0, 4, 0, 6'b000000};

        #1 rst_n = 1'b0;
        #3;
        chk("reset_step", {31'd0, step0}, 32'd0);
        chk("reset_pos", {29'd0, pos0}, 32'd0);
        chk("reset_leds", {26'd0, leds0}, 32'h3E);
        #9 rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            en = vecs[i].en;
            mode = vecs[i].mode;
            speed = vecs[i].speed;
            wait_step(0, g);
            chk($sformatf("vec%0d_gap", i), g, vecs[i].gap);
            chk($sformatf("vec%0d_pos", i), {29'd0, pos0}, vecs[i].pos);
            chk($sformatf("vec%0d_leds", i), {26'd0, leds0}, {26'd0, vecs[i].leds});
        end

        // Freeze mid-period, then resume: only the remaining two cycles of the period should elapse.
        repeat (2) @(posedge clk);
        #1 en = 1'b0;
        held = leds0;
        stepped = 1'b0;
        changed = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (step0) stepped = 1'b1;
            if (leds0 !== held) changed = 1'b1;
        end
        chk("frozen_step", {31'd0, stepped}, 32'd0);
        chk("frozen_leds", {31'd0, changed}, 32'd0);
        en = 1'b1;
        wait_step(0, g);
        chk("resume_gap", g, 2);
        chk("resume_leds", {26'd0, leds0}, 32'h3F);

        // Back to bounce, reach position 3, then reset asynchronously between edges.
        mode = 2'b00;
        wait_step(0, g);
        chk("bounce_restart_pos", {29'd0, pos0}, 32'd0);
        repeat (3) wait_step(0, g);
        chk("pre_reset_pos", {29'd0, pos0}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_pos", {29'd0, pos0}, 32'd0);
        chk("async_reset_leds", {26'd0, leds0}, 32'h3E);
        chk("async_reset_step", {31'd0, step0}, 32'd0);
        #1 rst_n = 1'b1;

        // 5-LED wrap-up: first step is the restart from bounce, then 1..4 and a compare-based wrap to 0.
        for (int i = 0; i < 6; i++) begin
            wait_step(1, g);
            chk($sformatf("n5_gap%0d", i), g, 4);
            chk($sformatf("n5_pos%0d", i), {29'd0, pos5}, exp5_pos[i]);
            chk($sformatf("n5_leds%0d", i), {27'd0, leds5}, {27'd0, exp5_leds[i]});
        end

        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rnd_step%0d", i), {31'd0, (i == 0) ? step0 : step5}, {31'd0, m_step[i]});
                chk($sformatf("rnd_pos%0d", i), {29'd0, (i == 0) ? pos0 : pos5}, m_pos[i]);
                chk($sformatf("rnd_leds%0d", i), (i == 0) ? {26'd0, leds0} : {27'd0, leds5}, m_leds[i]);
            end
            #1;
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) speed = 4'($urandom_range(0, 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=still running required=finished by 1ms");
        $fatal(1, "watchdog");
    end

endmodule
